// File: rtl/oam_dma_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : oam_dma_arbiter_if                                         |
// | Brief   : CPU-side and memory-side bus bundle for oam_dma_arbiter    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface oam_dma_arbiter_if;
   logic [15:0] cpu_address;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_nread;
   logic        cpu_nwrite;
   logic [15:0] mem_address;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_nread;
   logic        mem_nwrite;
   logic        mem_nsel;
   logic        dma_active;

   modport master (
      input  cpu_address, cpu_wdata, cpu_nread, cpu_nwrite, mem_rdata,
      output cpu_rdata, mem_address, mem_wdata, mem_nread, mem_nwrite, mem_nsel, dma_active
   );

   modport slave (
      output cpu_address, cpu_wdata, cpu_nread, cpu_nwrite, mem_rdata,
      input  cpu_rdata, mem_address, mem_wdata, mem_nread, mem_nwrite, mem_nsel, dma_active
   );
endinterface
`default_nettype wire

// File: rtl/oam_dma_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : oam_dma_arbiter                                            |
// | Brief   : Shares the memory bus between the CPU and an OAM DMA copy  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module oam_dma_arbiter #(
   parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
   parameter logic [15:0] DMA_DST_BASE = 16'hFE00,
   parameter int          DMA_LEN      = 160,
   parameter int          START_DELAY  = 1,
   parameter logic [7:0]  OPEN_BUS     = 8'hFF
) (
   input  logic              clock,
   input  logic              reset,
   oam_dma_arbiter_if.master bus
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DELAY = 2'd1,
      S_RD    = 2'd2,
      S_WR    = 2'd3
   } state_t;

   localparam logic [7:0] c_last_idx     = 8'(DMA_LEN - 1);
   localparam logic [1:0] c_delay_reload = (START_DELAY > 0) ? 2'(START_DELAY - 1) : 2'd0;
   localparam state_t     c_start_state  = (START_DELAY > 0) ? S_DELAY : S_RD;

   state_t     r_state, w_state_nxt;
   logic [7:0] r_dma_reg, w_dma_reg_nxt;
   logic [7:0] r_idx, w_idx_nxt;
   logic [7:0] r_latch, w_latch_nxt;
   logic [1:0] r_delay, w_delay_nxt;
   logic       r_restart_pend, w_restart_pend_nxt;
   logic [7:0] r_restart_val, w_restart_val_nxt;

   logic        w_reg_hit;
   logic        w_reg_write;
   logic [15:0] w_src_addr;
   logic [15:0] w_dst_addr;
   logic [15:0] w_mem_address;
   logic [7:0]  w_mem_wdata;
   logic        w_mem_nread;
   logic        w_mem_nwrite;
   logic [7:0]  w_cpu_rdata;

   assign w_reg_hit   = (bus.cpu_address == DMA_REG_ADDR);
   assign w_reg_write = w_reg_hit && !bus.cpu_nwrite;
   assign w_src_addr  = {r_dma_reg, 8'h00} + {8'h00, r_idx};
   assign w_dst_addr  = DMA_DST_BASE + {8'h00, r_idx};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_dma_reg      <= 8'h00;
         r_idx          <= 8'h00;
         r_latch        <= 8'h00;
         r_delay        <= 2'd0;
         r_restart_pend <= 1'b0;
         r_restart_val  <= 8'h00;
      end else begin
         r_state        <= w_state_nxt;
         r_dma_reg      <= w_dma_reg_nxt;
         r_idx          <= w_idx_nxt;
         r_latch        <= w_latch_nxt;
         r_delay        <= w_delay_nxt;
         r_restart_pend <= w_restart_pend_nxt;
         r_restart_val  <= w_restart_val_nxt;
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      w_dma_reg_nxt      = r_dma_reg;
      w_idx_nxt          = r_idx;
      w_latch_nxt        = r_latch;
      w_delay_nxt        = r_delay;
      w_restart_pend_nxt = r_restart_pend;
      w_restart_val_nxt  = r_restart_val;
      case (r_state)
         S_IDLE: begin
            if (w_reg_write) begin
               w_dma_reg_nxt = bus.cpu_wdata;
               w_idx_nxt     = 8'h00;
               w_delay_nxt   = c_delay_reload;
               w_state_nxt   = c_start_state;
            end
         end
         S_DELAY: begin
            if (w_reg_write) begin
               w_dma_reg_nxt = bus.cpu_wdata;
               w_delay_nxt   = c_delay_reload;
            end else if (r_delay == 2'd0) begin
               w_state_nxt = S_RD;
            end else begin
               w_delay_nxt = r_delay - 2'd1;
            end
         end
         S_RD: begin
            w_latch_nxt = bus.mem_rdata;
            w_state_nxt = S_WR;
            // A restart here is deferred until the pending write has landed
            if (w_reg_write) begin
               w_restart_pend_nxt = 1'b1;
               w_restart_val_nxt  = bus.cpu_wdata;
            end
         end
         default: begin
            if (w_reg_write || r_restart_pend) begin
               w_dma_reg_nxt      = w_reg_write ? bus.cpu_wdata : r_restart_val;
               w_idx_nxt          = 8'h00;
               w_delay_nxt        = c_delay_reload;
               w_restart_pend_nxt = 1'b0;
               w_state_nxt        = c_start_state;
            end else if (r_idx == c_last_idx) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_idx_nxt   = r_idx + 8'h01;
               w_state_nxt = S_RD;
            end
         end
      endcase
   end

   always_comb begin
      w_mem_address = bus.cpu_address;
      w_mem_wdata   = bus.cpu_wdata;
      w_mem_nread   = 1'b1;
      w_mem_nwrite  = 1'b1;
      w_cpu_rdata   = w_reg_hit ? r_dma_reg : OPEN_BUS;
      case (r_state)
         S_IDLE: begin
            if (!w_reg_hit) begin
               w_mem_nread  = bus.cpu_nread;
               w_mem_nwrite = bus.cpu_nwrite;
               w_cpu_rdata  = bus.mem_rdata;
            end
         end
         S_DELAY: begin
            w_mem_address = w_src_addr;
         end
         S_RD: begin
            w_mem_address = w_src_addr;
            w_mem_nread   = 1'b0;
         end
         default: begin
            w_mem_address = w_dst_addr;
            w_mem_wdata   = r_latch;
            w_mem_nwrite  = 1'b0;
         end
      endcase
      // Strobes must stay quiet for the whole reset pulse, even with CPU strobes low
      if (reset) begin
         w_mem_nread  = 1'b1;
         w_mem_nwrite = 1'b1;
      end
   end

   assign bus.mem_address = w_mem_address;
   assign bus.mem_wdata   = w_mem_wdata;
   assign bus.mem_nread   = w_mem_nread;
   assign bus.mem_nwrite  = w_mem_nwrite;
   assign bus.mem_nsel    = w_mem_nread & w_mem_nwrite;
   assign bus.cpu_rdata   = w_cpu_rdata;
   assign bus.dma_active  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_oam_dma_arbiter                                         |
// | Brief   : Scoreboard bench for oam_dma_arbiter with a 64 KiB memory  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_oam_dma_arbiter;
   typedef struct packed {
      logic [15:0] addr;
      logic        wr;
      logic [7:0]  data;
   } bus_txn_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   oam_dma_arbiter_if bus ();

   oam_dma_arbiter #(
      .DMA_REG_ADDR (16'hFF46),
      .DMA_DST_BASE (16'hFE00),
      .DMA_LEN      (160),
      .START_DELAY  (1),
      .OPEN_BUS     (8'hFF)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   logic [7:0] mem [0:65535];
   bus_txn_t   bus_q[$];
   logic [7:0] rd_q[$];
   int         n_checks = 0;
   int         n_pass = 0;
   int         active_cycles = 0;

   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   assign bus.mem_rdata = mem[bus.mem_address];

   always @(posedge clock) begin
      if (!bus.mem_nwrite) mem[bus.mem_address] = bus.mem_wdata;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every memory strobe and every CPU read is matched against the queues
   always @(negedge clock) begin
      bus_txn_t   t;
      logic [7:0] e;
      if (bus.dma_active) active_cycles++;
      if (!bus.mem_nread || !bus.mem_nwrite) begin
         if (bus_q.size() == 0) begin
            check("bus_unexpected_access_addr", 32'(bus.mem_address), 32'hFFFF_FFFF);
         end else begin
            t = bus_q.pop_front();
            check("bus_addr", 32'(bus.mem_address), 32'(t.addr));
            check("bus_is_write", 32'(!bus.mem_nwrite), 32'(t.wr));
            if (t.wr) check("bus_wdata", 32'(bus.mem_wdata), 32'(t.data));
         end
      end
      if (!bus.cpu_nread) begin
         if (rd_q.size() == 0) begin
            check("cpu_read_unexpected_addr", 32'(bus.cpu_address), 32'hFFFF_FFFF);
         end else begin
            e = rd_q.pop_front();
            check("cpu_rdata", 32'(bus.cpu_rdata), 32'(e));
         end
      end
   end

   // All tasks below start and end 1 time unit after a rising edge
   task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input bit on_bus);
      bus_txn_t t;
      bus.cpu_address = a;
      bus.cpu_nread   = 1'b0;
      rd_q.push_back(exp);
      if (on_bus) begin
         t.addr = a; t.wr = 1'b0; t.data = 8'h00;
         bus_q.push_back(t);
      end
      @(posedge clock); #1;
      bus.cpu_nread = 1'b1;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input bit on_bus);
      bus_txn_t t;
      bus.cpu_address = a;
      bus.cpu_wdata   = d;
      bus.cpu_nwrite  = 1'b0;
      if (on_bus) begin
         t.addr = a; t.wr = 1'b1; t.data = d;
         bus_q.push_back(t);
      end
      @(posedge clock); #1;
      bus.cpu_nwrite = 1'b1;
   endtask

   task automatic push_copy(input logic [7:0] page, input int first, input int last);
      bus_txn_t t;
      logic [15:0] src;
      for (int i = first; i <= last; i++) begin
         src    = {page, 8'h00} + 16'(i);
         t.addr = src; t.wr = 1'b0; t.data = 8'h00;
         bus_q.push_back(t);
         t.addr = 16'hFE00 + 16'(i); t.wr = 1'b1; t.data = pat(src);
         bus_q.push_back(t);
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.dma_active && n < 2000) begin
         @(posedge clock); #1;
         n++;
      end
      check({"dma_done_", name}, 32'(bus.dma_active), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int start_cnt;
      for (int a = 0; a < 65536; a++) mem[16'(a)] = pat(16'(a));
      bus.cpu_address = 16'h0000;
      bus.cpu_wdata   = 8'h00;
      bus.cpu_nread   = 1'b1;
      bus.cpu_nwrite  = 1'b1;

      // Reset: CPU write attempt must not reach memory
      repeat (2) @(posedge clock); #1;
      bus.cpu_address = 16'h8000;
      bus.cpu_wdata   = 8'h77;
      bus.cpu_nwrite  = 1'b0;
      @(negedge clock);
      check("reset_dma_active", 32'(bus.dma_active), 32'd0);
      check("reset_mem_nsel", 32'(bus.mem_nsel), 32'd1);
      @(posedge clock); #1;
      bus.cpu_nwrite = 1'b1;
      reset = 1'b0;
      check("reset_no_mem_write", 32'(mem[16'h8000]), 32'(pat(16'h8000)));
      cpu_read(16'hFF46, 8'h00, 1'b0);

      // Idle passthrough
      cpu_read(16'h8000, pat(16'h8000), 1'b1);
      cpu_write(16'h9000, 8'h33, 1'b1);
      cpu_read(16'h9000, 8'h33, 1'b1);

      // Plain copy from C1 with CPU locked out part-way through
      start_cnt = active_cycles;
      push_copy(8'hC1, 0, 159);
      cpu_write(16'hFF46, 8'hC1, 1'b0);
      repeat (5) @(posedge clock); #1;
      cpu_read(16'hC000, 8'hFF, 1'b0);
      cpu_write(16'hC000, 8'h55, 1'b0);
      cpu_read(16'hFF46, 8'hC1, 1'b0);
      wait_idle("copy_c1");
      repeat (2) @(posedge clock); #1;
      check("active_cycles", 32'(active_cycles - start_cnt), 32'd321);
      check("c000_untouched", 32'(mem[16'hC000]), 32'(pat(16'hC000)));
      cpu_read(16'hC000, pat(16'hC000), 1'b1);
      check("dst_first", 32'(mem[16'hFE00]), 32'(pat(16'hC100)));
      check("dst_last", 32'(mem[16'hFE9F]), 32'(pat(16'hC19F)));
      check("dst_past_end", 32'(mem[16'hFEA0]), 32'(pat(16'hFEA0)));
      cpu_read(16'hFF46, 8'hC1, 1'b0);

      // Restart during byte 10 read: byte 10 write still lands, then fresh copy from D0
      push_copy(8'hC1, 0, 10);
      cpu_write(16'hFF46, 8'hC1, 1'b0);
      repeat (21) @(posedge clock); #1;
      push_copy(8'hD0, 0, 159);
      cpu_write(16'hFF46, 8'hD0, 1'b0);
      wait_idle("restart");
      check("restart_dst_first", 32'(mem[16'hFE00]), 32'(pat(16'hD000)));
      check("restart_dst_0a", 32'(mem[16'hFE0A]), 32'(pat(16'hD00A)));
      check("restart_dst_last", 32'(mem[16'hFE9F]), 32'(pat(16'hD09F)));

      // Source page FF, top of address space
      push_copy(8'hFF, 0, 159);
      cpu_write(16'hFF46, 8'hFF, 1'b0);
      wait_idle("src_ff");
      check("ff_dst_last", 32'(mem[16'hFE9F]), 32'(pat(16'hFF9F)));
      cpu_read(16'hFF46, 8'hFF, 1'b0);

      // Reset during byte 50 read aborts the copy
      for (int i = 0; i < 160; i++) mem[16'hFE00 + 16'(i)] = 8'hEE;
      push_copy(8'hC1, 0, 49);
      cpu_write(16'hFF46, 8'hC1, 1'b0);
      repeat (101) @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      check("abort_dma_active", 32'(bus.dma_active), 32'd0);
      check("abort_mem_nsel", 32'(bus.mem_nsel), 32'd1);
      repeat (2) @(posedge clock); #1;
      reset = 1'b0;
      cpu_read(16'hFF46, 8'h00, 1'b0);
      check("abort_byte49", 32'(mem[16'hFE31]), 32'(pat(16'hC131)));
      check("abort_byte50", 32'(mem[16'hFE32]), 32'hEE);
      check("abort_byte159", 32'(mem[16'hFE9F]), 32'hEE);

      repeat (3) @(posedge clock); #1;
      check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
      check("cpu_queue_drained", 32'(rd_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
